// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter: access-size masks, master ids,
// and the mask normalisation used on the memory bus.
package dmem_pkg;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  // Any encoding other than byte or half is a full word access.
  function automatic logic [3:0] norm_mask(input logic [3:0] m);
    case (m)
      MASK_B:  return MASK_B;
      MASK_H:  return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the two data-memory masters.
// Lock inputs are driven low by the top level unless DMEM_ARB_LOCK_EN is set.
module dmem_arb_pick
  import dmem_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       starve,
  input  logic       lock_active,
  input  logic       lock_owner,
  output logic [1:0] gnt
);

  logic winner;

  always_comb begin
    gnt    = 2'b00;
    winner = M_CPU;
    if (lock_active) begin
      // lock_active already implies the owner is requesting
      gnt[lock_owner] = 1'b1;
    end else if (&req) begin
      if (FIXED_PRIO != 0) winner = starve ? M_DBG : M_CPU;
      else                 winner = (last == M_DBG) ? M_CPU : M_DBG;
      gnt[winner] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data memory (CPU LSU = M0,
// debug/DMA = M1). Optional bus locking is enabled with DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int MAX_WAIT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_mask,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_mask,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic        m0_lock,
  input  logic        m1_lock,
`endif
  output logic        mem_ce,
  output logic        mem_we,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_w_mask,
  output logic [3:0]  mem_r_mask,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);

  logic       last;
  logic [7:0] wait_cnt;
  logic       starve;
  logic [1:0] gnt;
  logic       gnt_any;
  logic       win;
  logic       lock_active;
  logic       lock_owner;

  assign starve = (FIXED_PRIO != 0) && (wait_cnt >= MAX_WAIT_W);

`ifdef DMEM_ARB_LOCK_EN
  logic locked;

  // The lock holds only while the owner keeps both req and lock high.
  assign lock_active = locked &&
                       ((lock_owner == M_DBG) ? (m1_req && m1_lock) : (m0_req && m0_lock));

  always_ff @(posedge clk) begin
    if (rst) begin
      locked     <= 1'b0;
      lock_owner <= M_CPU;
    end else if (gnt_any) begin
      locked     <= (win == M_DBG) ? m1_lock : m0_lock;
      lock_owner <= win;
    end else begin
      locked     <= 1'b0;
    end
  end
`else
  assign lock_active = 1'b0;
  assign lock_owner  = M_CPU;
`endif

  dmem_arb_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .req         ({m1_req, m0_req}),
    .last        (last),
    .starve      (starve),
    .lock_active (lock_active),
    .lock_owner  (lock_owner),
    .gnt         (gnt)
  );

  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];
  assign gnt_any = |gnt;
  assign win     = gnt[1];

  always_comb begin
    mem_ce     = 1'b0;
    mem_we     = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_w_mask = '0;
    mem_r_mask = '0;
    if (gnt_any) begin
      mem_ce     = 1'b1;
      mem_we     = win ? m1_we : m0_we;
      mem_rd     = !mem_we;
      mem_addr   = win ? m1_addr : m0_addr;
      mem_wdata  = win ? m1_wdata : m0_wdata;
      mem_w_mask = norm_mask(win ? m1_mask : m0_mask);
      mem_r_mask = mem_w_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= M_DBG;
      wait_cnt  <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt[0] && !m0_we;
      m1_rvalid <= gnt[1] && !m1_we;
      if (gnt[0] && !m0_we) m0_rdata <= mem_rdata;
      if (gnt[1] && !m1_we) m1_rdata <= mem_rdata;
      if (gnt_any) last <= win;
      // Saturate so a long lock cannot wrap the starvation counter.
      if (m1_req && !gnt[1])
        wait_cnt <= (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance with a small memory model and
// a fixed-priority instance (MAX_WAIT=3) checked on grants only.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_mask, m1_mask;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_lock, m1_lock;
  logic        mem_ce, mem_we, mem_rd;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_w_mask, mem_r_mask;

  logic        fp_m0_req, fp_m1_req, fp_m0_gnt, fp_m1_gnt;
  logic        fp_m0_rvalid, fp_m1_rvalid, fp_ce, fp_we, fp_rd;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_addr, fp_wdata;
  logic [3:0]  fp_w_mask, fp_r_mask;
  logic [31:0] fp_mem_rdata = 32'h0;
  logic        tie0 = 1'b0;

  dmem_arbiter #(.FIXED_PRIO(0), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_w_mask(mem_w_mask), .mem_r_mask(mem_r_mask),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.FIXED_PRIO(1), .MAX_WAIT(3)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(fp_m0_req), .m0_we(tie0), .m0_addr(32'h40), .m0_wdata(32'h0), .m0_mask(4'hF),
    .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
    .m1_req(fp_m1_req), .m1_we(tie0), .m1_addr(32'h44), .m1_wdata(32'h0), .m1_mask(4'hF),
    .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .m0_lock(tie0), .m1_lock(tie0),
`endif
    .mem_ce(fp_ce), .mem_we(fp_we), .mem_rd(fp_rd), .mem_addr(fp_addr),
    .mem_wdata(fp_wdata), .mem_w_mask(fp_w_mask), .mem_r_mask(fp_r_mask),
    .mem_rdata(fp_mem_rdata)
  );

  // Memory model: word-addressed, byte-lane write enables, read data masked by lane.
  logic [31:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);

  always @(posedge clk)
    if (mem_ce && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_w_mask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

  always_comb begin
    mem_rdata = 32'h0;
    if (mem_rd)
      for (int b = 0; b < 4; b++)
        if (mem_r_mask[b]) mem_rdata[8*b +: 8] = mem[mem_addr[7:2]][8*b +: 8];
  end

  // Scoreboard
  typedef struct {
    logic [1:0]  gnt;
    logic        ce, we, rd;
    logic [31:0] addr, wdata;
    logic [3:0]  wm, rm;
  } exp_t;

  exp_t        cyc_q[$];
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [1:0]  fp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    chk32("gnt_wo_req", 32'((m0_gnt && !m0_req) || (m1_gnt && !m1_req)), 32'h0);
    chk32("fp_gnt_wo_req", 32'((fp_m0_gnt && !fp_m0_req) || (fp_m1_gnt && !fp_m1_req)), 32'h0);
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk32("gnt", 32'({m1_gnt, m0_gnt}), 32'(e.gnt));
      chk32("mem_ctrl", 32'({mem_ce, mem_we, mem_rd, mem_w_mask, mem_r_mask}),
            32'({e.ce, e.we, e.rd, e.wm, e.rm}));
      chk32("mem_addr", mem_addr, e.addr);
      chk32("mem_wdata", mem_wdata, e.wdata);
    end
    if (m0_rvalid) begin
      if (exp0_q.size() == 0) chk32("m0_rvalid_unexpected", 32'h1, 32'h0);
      else chk32("m0_rdata", m0_rdata, exp0_q.pop_front());
    end
    if (m1_rvalid) begin
      if (exp1_q.size() == 0) chk32("m1_rvalid_unexpected", 32'h1, 32'h0);
      else chk32("m1_rdata", m1_rdata, exp1_q.pop_front());
    end
    if (fp_q.size() > 0) chk32("fp_gnt", 32'({fp_m1_gnt, fp_m0_gnt}), 32'(fp_q.pop_front()));
  end

  // Drivers
  task automatic set_m0(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] k);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; m0_mask = k;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] k);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; m1_mask = k;
  endtask

  // One cycle with the current inputs; eg is the expected grant, erd the read data
  // expected one cycle later if the winner is reading.
  task automatic step(input logic [1:0] eg, input logic [31:0] erd);
    exp_t e;
    logic [3:0] k;
    e = '{gnt: eg, ce: 1'b0, we: 1'b0, rd: 1'b0, addr: 32'h0, wdata: 32'h0, wm: 4'h0, rm: 4'h0};
    k = 4'h0;
    if (eg == 2'b01) begin
      e.we = m0_we; e.addr = m0_addr; e.wdata = m0_wdata; k = m0_mask;
    end else if (eg == 2'b10) begin
      e.we = m1_we; e.addr = m1_addr; e.wdata = m1_wdata; k = m1_mask;
    end
    if (eg != 2'b00) begin
      e.ce = 1'b1;
      e.rd = !e.we;
      e.wm = (k == 4'b0001) ? 4'b0001 : (k == 4'b0011) ? 4'b0011 : 4'b1111;
      e.rm = e.wm;
    end
    cyc_q.push_back(e);
    if (!rst && eg == 2'b01 && !m0_we) exp0_q.push_back(erd);
    if (!rst && eg == 2'b10 && !m1_we) exp1_q.push_back(erd);
    @(posedge clk); #1;
  endtask

  task automatic fp_step(input logic [1:0] eg);
    fp_q.push_back(eg);
    @(posedge clk); #1;
  endtask

  localparam logic [1:0] G0 = 2'b01;
  localparam logic [1:0] G1 = 2'b10;
  logic [1:0] fp_pat [0:7] = '{G0, G0, G0, G1, G0, G0, G0, G1};

  initial begin
    rst = 1'b1;
    set_m0(0, 0, 0, 0, 4'hF);
    set_m1(0, 0, 0, 0, 4'hF);
    m0_lock = 1'b0; m1_lock = 1'b0;
    fp_m0_req = 1'b0; fp_m1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk32("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
    chk32("rst_m0_rdata", m0_rdata, 32'h0);
    chk32("rst_m1_rdata", m1_rdata, 32'h0);

    // Single M0 read, then single M1 read
    set_m0(1, 0, 32'h10, 0, 4'hF); step(G0, 32'h1000_0004);
    set_m0(0, 0, 0, 0, 4'hF);
    set_m1(1, 0, 32'h14, 0, 4'hF); step(G1, 32'h1000_0005);

    // Round-robin contention: last winner was M1
    set_m0(1, 0, 32'h18, 0, 4'hF);
    set_m1(1, 0, 32'h1C, 0, 4'hF);
    step(G0, 32'h1000_0006); step(G1, 32'h1000_0007);
    step(G0, 32'h1000_0006); step(G1, 32'h1000_0007);
    set_m0(0, 0, 0, 0, 4'hF); set_m1(0, 0, 0, 0, 4'hF);
    step(2'b00, 0);

    // Byte write by M1, masked byte read back by M0
    set_m1(1, 1, 32'h20, 32'h0000_00AB, 4'b0001); step(G1, 0);
    set_m1(0, 0, 0, 0, 4'hF);
    set_m0(1, 0, 32'h20, 0, 4'b0001); step(G0, 32'h0000_00AB);

    // Half write by M0, word read by M1
    set_m0(1, 1, 32'h24, 32'h1234_CDEF, 4'b0011); step(G0, 0);
    set_m0(0, 0, 0, 0, 4'hF);
    set_m1(1, 0, 32'h24, 0, 4'hF); step(G1, 32'h1000_CDEF);
    set_m1(0, 0, 0, 0, 4'hF);

    // Unlisted mask encoding acts as a full word
    set_m0(1, 1, 32'h28, 32'hDEAD_BEEF, 4'b0101); step(G0, 0);
    set_m0(1, 0, 32'h28, 0, 4'hF); step(G0, 32'hDEAD_BEEF);

    // Reset one cycle after a granted read; access in the reset cycle still drives
    set_m0(1, 0, 32'h10, 0, 4'hF); step(G0, 32'h1000_0004);
    set_m0(0, 0, 0, 0, 4'hF);
    set_m1(1, 0, 32'h14, 0, 4'hF);
    rst = 1'b1; step(G1, 0);
    rst = 1'b0;
    chk32("post_rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
    chk32("post_rst_m0_rdata", m0_rdata, 32'h0);
    chk32("post_rst_m1_rdata", m1_rdata, 32'h0);
    set_m0(1, 0, 32'h18, 0, 4'hF);
    set_m1(1, 0, 32'h1C, 0, 4'hF);
    step(G0, 32'h1000_0006); step(G1, 32'h1000_0007);
    set_m0(0, 0, 0, 0, 4'hF); set_m1(0, 0, 0, 0, 4'hF);
    step(2'b00, 0);

`ifdef DMEM_ARB_LOCK_EN
    // M1 takes the lock alone, then keeps the memory despite M0 and round-robin
    set_m1(1, 0, 32'h14, 0, 4'hF); m1_lock = 1'b1;
    step(G1, 32'h1000_0005);
    set_m0(1, 0, 32'h18, 0, 4'hF);
    step(G1, 32'h1000_0005); step(G1, 32'h1000_0005);
    m1_lock = 1'b0;
    step(G0, 32'h1000_0006);
    set_m0(0, 0, 0, 0, 4'hF); set_m1(0, 0, 0, 0, 4'hF);
    step(2'b00, 0);
`endif

    // Fixed priority with MAX_WAIT=3
    fp_m0_req = 1'b1; fp_m1_req = 1'b1;
    for (int i = 0; i < 8; i++) fp_step(fp_pat[i]);
    fp_step(G0); fp_step(G0);
    fp_m1_req = 1'b0; fp_step(G0);
    fp_m1_req = 1'b1;
    fp_step(G0); fp_step(G0); fp_step(G0); fp_step(G1);
    fp_m0_req = 1'b0; fp_m1_req = 1'b0;
    fp_step(2'b00);

    repeat (3) @(posedge clk);
    #1;
    chk32("cyc_q_drained", 32'(cyc_q.size()), 32'h0);
    chk32("exp0_q_drained", 32'(exp0_q.size()), 32'h0);
    chk32("exp1_q_drained", 32'(exp1_q.size()), 32'h0);
    chk32("fp_q_drained", 32'(fp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
